// File: rtl/ysyx_axi_pkg.sv
// Shared constants and FSM state types for the two-port AXI arbiter.
package ysyx_axi_pkg;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;
  localparam int IDX_W   = 1;  // requester index width (two requesters)

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
endpackage

// File: rtl/ysyx_rr_arb2.sv
// Two-request round-robin arbiter: combinational winner plus 1-bit pointer.
module ysyx_rr_arb2
  import ysyx_axi_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic             done,
  input  logic [IDX_W-1:0] done_sel,
  output logic [IDX_W-1:0] win
);
  logic [IDX_W-1:0] ptr;

  // Single requester wins outright; on contention the pointer decides.
  always_comb begin
    win = req[1] & (~req[0] | ptr);
  end

  // On transaction completion the pointer moves to the requester that did not win.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr <= '0;
    else if (done) ptr <= ~done_sel;
  end
endmodule

// File: rtl/ysyx_axi_arbiter.sv
// Two-requester AXI4 arbiter with independent read and write paths.
module ysyx_axi_arbiter
  import ysyx_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic clock,
  input  logic reset,
  // requester 0
  input  logic s0_ar_valid, output logic s0_ar_ready, input logic [ADDR_W-1:0] s0_ar_addr,
  input  logic [ID_W-1:0] s0_ar_id, input logic [LEN_W-1:0] s0_ar_len,
  input  logic [SIZE_W-1:0] s0_ar_size, input logic [BURST_W-1:0] s0_ar_burst,
  output logic s0_r_valid, input logic s0_r_ready, output logic [DATA_W-1:0] s0_r_data,
  output logic [RESP_W-1:0] s0_r_resp, output logic s0_r_last, output logic [ID_W-1:0] s0_r_id,
  input  logic s0_aw_valid, output logic s0_aw_ready, input logic [ADDR_W-1:0] s0_aw_addr,
  input  logic [ID_W-1:0] s0_aw_id, input logic [LEN_W-1:0] s0_aw_len,
  input  logic [SIZE_W-1:0] s0_aw_size, input logic [BURST_W-1:0] s0_aw_burst,
  input  logic s0_w_valid, output logic s0_w_ready, input logic [DATA_W-1:0] s0_w_data,
  input  logic [DATA_W/8-1:0] s0_w_strb, input logic s0_w_last,
  output logic s0_b_valid, input logic s0_b_ready, output logic [RESP_W-1:0] s0_b_resp,
  output logic [ID_W-1:0] s0_b_id,
  // requester 1
  input  logic s1_ar_valid, output logic s1_ar_ready, input logic [ADDR_W-1:0] s1_ar_addr,
  input  logic [ID_W-1:0] s1_ar_id, input logic [LEN_W-1:0] s1_ar_len,
  input  logic [SIZE_W-1:0] s1_ar_size, input logic [BURST_W-1:0] s1_ar_burst,
  output logic s1_r_valid, input logic s1_r_ready, output logic [DATA_W-1:0] s1_r_data,
  output logic [RESP_W-1:0] s1_r_resp, output logic s1_r_last, output logic [ID_W-1:0] s1_r_id,
  input  logic s1_aw_valid, output logic s1_aw_ready, input logic [ADDR_W-1:0] s1_aw_addr,
  input  logic [ID_W-1:0] s1_aw_id, input logic [LEN_W-1:0] s1_aw_len,
  input  logic [SIZE_W-1:0] s1_aw_size, input logic [BURST_W-1:0] s1_aw_burst,
  input  logic s1_w_valid, output logic s1_w_ready, input logic [DATA_W-1:0] s1_w_data,
  input  logic [DATA_W/8-1:0] s1_w_strb, input logic s1_w_last,
  output logic s1_b_valid, input logic s1_b_ready, output logic [RESP_W-1:0] s1_b_resp,
  output logic [ID_W-1:0] s1_b_id,
  // downstream master
  output logic io_master_ar_valid, input logic io_master_ar_ready,
  output logic [ADDR_W-1:0] io_master_ar_addr, output logic [ID_W-1:0] io_master_ar_id,
  output logic [LEN_W-1:0] io_master_ar_len, output logic [SIZE_W-1:0] io_master_ar_size,
  output logic [BURST_W-1:0] io_master_ar_burst,
  input  logic io_master_r_valid, output logic io_master_r_ready,
  input  logic [DATA_W-1:0] io_master_r_data, input logic [RESP_W-1:0] io_master_r_resp,
  input  logic io_master_r_last, input logic [ID_W-1:0] io_master_r_id,
  output logic io_master_aw_valid, input logic io_master_aw_ready,
  output logic [ADDR_W-1:0] io_master_aw_addr, output logic [ID_W-1:0] io_master_aw_id,
  output logic [LEN_W-1:0] io_master_aw_len, output logic [SIZE_W-1:0] io_master_aw_size,
  output logic [BURST_W-1:0] io_master_aw_burst,
  output logic io_master_w_valid, input logic io_master_w_ready,
  output logic [DATA_W-1:0] io_master_w_data, output logic [DATA_W/8-1:0] io_master_w_strb,
  output logic io_master_w_last,
  input  logic io_master_b_valid, output logic io_master_b_ready,
  input  logic [RESP_W-1:0] io_master_b_resp, input logic [ID_W-1:0] io_master_b_id
);
  rd_state_t        rd_state, rd_next;
  wr_state_t        wr_state, wr_next;
  logic [IDX_W-1:0] rd_sel, wr_sel, rd_win, wr_win;
  logic             rd_done, wr_done;

  ysyx_rr_arb2 u_rd_arb (
    .clock(clock), .reset(reset), .req({s1_ar_valid, s0_ar_valid}),
    .done(rd_done), .done_sel(rd_sel), .win(rd_win)
  );

  ysyx_rr_arb2 u_wr_arb (
    .clock(clock), .reset(reset), .req({s1_aw_valid, s0_aw_valid}),
    .done(wr_done), .done_sel(wr_sel), .win(wr_win)
  );

  // State registers; the grant is latched only on the IDLE->ADDR transition and held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
      rd_sel   <= '0;
      wr_sel   <= '0;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
      if (rd_state == R_IDLE && rd_next == R_ADDR) rd_sel <= rd_win;
      if (wr_state == W_IDLE && wr_next == W_ADDR) wr_sel <= wr_win;
    end
  end

  // Read path: next state and AR/R routing to the granted requester only.
  always_comb begin
    rd_next            = rd_state;
    rd_done            = 1'b0;
    io_master_ar_valid = 1'b0;
    io_master_ar_addr  = '0;
    io_master_ar_id    = '0;
    io_master_ar_len   = '0;
    io_master_ar_size  = '0;
    io_master_ar_burst = '0;
    io_master_r_ready  = 1'b0;
    s0_ar_ready = 1'b0; s1_ar_ready = 1'b0;
    s0_r_valid = 1'b0; s0_r_data = '0; s0_r_resp = '0; s0_r_last = 1'b0; s0_r_id = '0;
    s1_r_valid = 1'b0; s1_r_data = '0; s1_r_resp = '0; s1_r_last = 1'b0; s1_r_id = '0;
    case (rd_state)
      R_IDLE: if (s0_ar_valid || s1_ar_valid) rd_next = R_ADDR;
      R_ADDR: begin
        io_master_ar_valid = rd_sel[0] ? s1_ar_valid : s0_ar_valid;
        io_master_ar_addr  = rd_sel[0] ? s1_ar_addr  : s0_ar_addr;
        io_master_ar_id    = rd_sel[0] ? s1_ar_id    : s0_ar_id;
        io_master_ar_len   = rd_sel[0] ? s1_ar_len   : s0_ar_len;
        io_master_ar_size  = rd_sel[0] ? s1_ar_size  : s0_ar_size;
        io_master_ar_burst = rd_sel[0] ? s1_ar_burst : s0_ar_burst;
        s0_ar_ready = !rd_sel[0] && io_master_ar_ready;
        s1_ar_ready =  rd_sel[0] && io_master_ar_ready;
        if (io_master_ar_valid && io_master_ar_ready) rd_next = R_DATA;
      end
      R_DATA: begin
        io_master_r_ready = rd_sel[0] ? s1_r_ready : s0_r_ready;
        if (rd_sel[0]) begin
          s1_r_valid = io_master_r_valid; s1_r_data = io_master_r_data;
          s1_r_resp  = io_master_r_resp;  s1_r_last = io_master_r_last; s1_r_id = io_master_r_id;
        end else begin
          s0_r_valid = io_master_r_valid; s0_r_data = io_master_r_data;
          s0_r_resp  = io_master_r_resp;  s0_r_last = io_master_r_last; s0_r_id = io_master_r_id;
        end
        if (io_master_r_valid && io_master_r_ready && io_master_r_last) begin
          rd_next = R_IDLE;
          rd_done = 1'b1;
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Write path: next state and AW/W/B routing to the granted requester only.
  always_comb begin
    wr_next            = wr_state;
    wr_done            = 1'b0;
    io_master_aw_valid = 1'b0;
    io_master_aw_addr  = '0;
    io_master_aw_id    = '0;
    io_master_aw_len   = '0;
    io_master_aw_size  = '0;
    io_master_aw_burst = '0;
    io_master_w_valid  = 1'b0;
    io_master_w_data   = '0;
    io_master_w_strb   = '0;
    io_master_w_last   = 1'b0;
    io_master_b_ready  = 1'b0;
    s0_aw_ready = 1'b0; s1_aw_ready = 1'b0;
    s0_w_ready  = 1'b0; s1_w_ready  = 1'b0;
    s0_b_valid = 1'b0; s0_b_resp = '0; s0_b_id = '0;
    s1_b_valid = 1'b0; s1_b_resp = '0; s1_b_id = '0;
    case (wr_state)
      W_IDLE: if (s0_aw_valid || s1_aw_valid) wr_next = W_ADDR;
      W_ADDR: begin
        io_master_aw_valid = wr_sel[0] ? s1_aw_valid : s0_aw_valid;
        io_master_aw_addr  = wr_sel[0] ? s1_aw_addr  : s0_aw_addr;
        io_master_aw_id    = wr_sel[0] ? s1_aw_id    : s0_aw_id;
        io_master_aw_len   = wr_sel[0] ? s1_aw_len   : s0_aw_len;
        io_master_aw_size  = wr_sel[0] ? s1_aw_size  : s0_aw_size;
        io_master_aw_burst = wr_sel[0] ? s1_aw_burst : s0_aw_burst;
        s0_aw_ready = !wr_sel[0] && io_master_aw_ready;
        s1_aw_ready =  wr_sel[0] && io_master_aw_ready;
        if (io_master_aw_valid && io_master_aw_ready) wr_next = W_DATA;
      end
      W_DATA: begin
        io_master_w_valid = wr_sel[0] ? s1_w_valid : s0_w_valid;
        io_master_w_data  = wr_sel[0] ? s1_w_data  : s0_w_data;
        io_master_w_strb  = wr_sel[0] ? s1_w_strb  : s0_w_strb;
        io_master_w_last  = wr_sel[0] ? s1_w_last  : s0_w_last;
        s0_w_ready = !wr_sel[0] && io_master_w_ready;
        s1_w_ready =  wr_sel[0] && io_master_w_ready;
        if (io_master_w_valid && io_master_w_ready && io_master_w_last) wr_next = W_RESP;
      end
      W_RESP: begin
        io_master_b_ready = wr_sel[0] ? s1_b_ready : s0_b_ready;
        if (wr_sel[0]) begin
          s1_b_valid = io_master_b_valid; s1_b_resp = io_master_b_resp; s1_b_id = io_master_b_id;
        end else begin
          s0_b_valid = io_master_b_valid; s0_b_resp = io_master_b_resp; s0_b_id = io_master_b_id;
        end
        if (io_master_b_valid && io_master_b_ready) begin
          wr_next = W_IDLE;
          wr_done = 1'b1;
        end
      end
      default: wr_next = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ysyx_axi_arbiter.sv
// Directed bench for ysyx_axi_arbiter: read-path vector table plus write/reset sequences.
module tb_ysyx_axi_arbiter;
  localparam int AW = 32, DW = 64, IW = 4;

  logic clock = 1'b0, reset;
  always #5 clock = ~clock;

  logic s0_ar_valid, s0_ar_ready; logic [AW-1:0] s0_ar_addr; logic [IW-1:0] s0_ar_id;
  logic [7:0] s0_ar_len; logic [2:0] s0_ar_size; logic [1:0] s0_ar_burst;
  logic s0_r_valid, s0_r_ready; logic [DW-1:0] s0_r_data; logic [1:0] s0_r_resp;
  logic s0_r_last; logic [IW-1:0] s0_r_id;
  logic s0_aw_valid, s0_aw_ready; logic [AW-1:0] s0_aw_addr; logic [IW-1:0] s0_aw_id;
  logic [7:0] s0_aw_len; logic [2:0] s0_aw_size; logic [1:0] s0_aw_burst;
  logic s0_w_valid, s0_w_ready; logic [DW-1:0] s0_w_data; logic [DW/8-1:0] s0_w_strb; logic s0_w_last;
  logic s0_b_valid, s0_b_ready; logic [1:0] s0_b_resp; logic [IW-1:0] s0_b_id;

  logic s1_ar_valid, s1_ar_ready; logic [AW-1:0] s1_ar_addr; logic [IW-1:0] s1_ar_id;
  logic [7:0] s1_ar_len; logic [2:0] s1_ar_size; logic [1:0] s1_ar_burst;
  logic s1_r_valid, s1_r_ready; logic [DW-1:0] s1_r_data; logic [1:0] s1_r_resp;
  logic s1_r_last; logic [IW-1:0] s1_r_id;
  logic s1_aw_valid, s1_aw_ready; logic [AW-1:0] s1_aw_addr; logic [IW-1:0] s1_aw_id;
  logic [7:0] s1_aw_len; logic [2:0] s1_aw_size; logic [1:0] s1_aw_burst;
  logic s1_w_valid, s1_w_ready; logic [DW-1:0] s1_w_data; logic [DW/8-1:0] s1_w_strb; logic s1_w_last;
  logic s1_b_valid, s1_b_ready; logic [1:0] s1_b_resp; logic [IW-1:0] s1_b_id;

  logic m_ar_valid, m_ar_ready; logic [AW-1:0] m_ar_addr; logic [IW-1:0] m_ar_id;
  logic [7:0] m_ar_len; logic [2:0] m_ar_size; logic [1:0] m_ar_burst;
  logic m_r_valid, m_r_ready; logic [DW-1:0] m_r_data; logic [1:0] m_r_resp;
  logic m_r_last; logic [IW-1:0] m_r_id;
  logic m_aw_valid, m_aw_ready; logic [AW-1:0] m_aw_addr; logic [IW-1:0] m_aw_id;
  logic [7:0] m_aw_len; logic [2:0] m_aw_size; logic [1:0] m_aw_burst;
  logic m_w_valid, m_w_ready; logic [DW-1:0] m_w_data; logic [DW/8-1:0] m_w_strb; logic m_w_last;
  logic m_b_valid, m_b_ready; logic [1:0] m_b_resp; logic [IW-1:0] m_b_id;

  ysyx_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clock(clock), .reset(reset),
    .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready), .s0_ar_addr(s0_ar_addr), .s0_ar_id(s0_ar_id),
    .s0_ar_len(s0_ar_len), .s0_ar_size(s0_ar_size), .s0_ar_burst(s0_ar_burst),
    .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready), .s0_r_data(s0_r_data), .s0_r_resp(s0_r_resp),
    .s0_r_last(s0_r_last), .s0_r_id(s0_r_id),
    .s0_aw_valid(s0_aw_valid), .s0_aw_ready(s0_aw_ready), .s0_aw_addr(s0_aw_addr), .s0_aw_id(s0_aw_id),
    .s0_aw_len(s0_aw_len), .s0_aw_size(s0_aw_size), .s0_aw_burst(s0_aw_burst),
    .s0_w_valid(s0_w_valid), .s0_w_ready(s0_w_ready), .s0_w_data(s0_w_data), .s0_w_strb(s0_w_strb),
    .s0_w_last(s0_w_last),
    .s0_b_valid(s0_b_valid), .s0_b_ready(s0_b_ready), .s0_b_resp(s0_b_resp), .s0_b_id(s0_b_id),
    .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready), .s1_ar_addr(s1_ar_addr), .s1_ar_id(s1_ar_id),
    .s1_ar_len(s1_ar_len), .s1_ar_size(s1_ar_size), .s1_ar_burst(s1_ar_burst),
    .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready), .s1_r_data(s1_r_data), .s1_r_resp(s1_r_resp),
    .s1_r_last(s1_r_last), .s1_r_id(s1_r_id),
    .s1_aw_valid(s1_aw_valid), .s1_aw_ready(s1_aw_ready), .s1_aw_addr(s1_aw_addr), .s1_aw_id(s1_aw_id),
    .s1_aw_len(s1_aw_len), .s1_aw_size(s1_aw_size), .s1_aw_burst(s1_aw_burst),
    .s1_w_valid(s1_w_valid), .s1_w_ready(s1_w_ready), .s1_w_data(s1_w_data), .s1_w_strb(s1_w_strb),
    .s1_w_last(s1_w_last),
    .s1_b_valid(s1_b_valid), .s1_b_ready(s1_b_ready), .s1_b_resp(s1_b_resp), .s1_b_id(s1_b_id),
    .io_master_ar_valid(m_ar_valid), .io_master_ar_ready(m_ar_ready), .io_master_ar_addr(m_ar_addr),
    .io_master_ar_id(m_ar_id), .io_master_ar_len(m_ar_len), .io_master_ar_size(m_ar_size),
    .io_master_ar_burst(m_ar_burst),
    .io_master_r_valid(m_r_valid), .io_master_r_ready(m_r_ready), .io_master_r_data(m_r_data),
    .io_master_r_resp(m_r_resp), .io_master_r_last(m_r_last), .io_master_r_id(m_r_id),
    .io_master_aw_valid(m_aw_valid), .io_master_aw_ready(m_aw_ready), .io_master_aw_addr(m_aw_addr),
    .io_master_aw_id(m_aw_id), .io_master_aw_len(m_aw_len), .io_master_aw_size(m_aw_size),
    .io_master_aw_burst(m_aw_burst),
    .io_master_w_valid(m_w_valid), .io_master_w_ready(m_w_ready), .io_master_w_data(m_w_data),
    .io_master_w_strb(m_w_strb), .io_master_w_last(m_w_last),
    .io_master_b_valid(m_b_valid), .io_master_b_ready(m_b_ready), .io_master_b_resp(m_b_resp),
    .io_master_b_id(m_b_id)
  );

  // OR of every DUT output: must be 0 in reset and whenever both paths are idle.
  logic any_out;
  assign any_out = |{s0_ar_ready, s0_r_valid, s0_r_data, s0_r_resp, s0_r_last, s0_r_id,
                     s0_aw_ready, s0_w_ready, s0_b_valid, s0_b_resp, s0_b_id,
                     s1_ar_ready, s1_r_valid, s1_r_data, s1_r_resp, s1_r_last, s1_r_id,
                     s1_aw_ready, s1_w_ready, s1_b_valid, s1_b_resp, s1_b_id,
                     m_ar_valid, m_ar_addr, m_ar_id, m_ar_len, m_ar_size, m_ar_burst, m_r_ready,
                     m_aw_valid, m_aw_addr, m_aw_id, m_aw_len, m_aw_size, m_aw_burst,
                     m_w_valid, m_w_data, m_w_strb, m_w_last, m_b_ready};

  int tests = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {s0_ar_valid, s0_ar_addr, s0_ar_id, s0_ar_len, s0_ar_size, s0_ar_burst, s0_r_ready} = '0;
    {s0_aw_valid, s0_aw_addr, s0_aw_id, s0_aw_len, s0_aw_size, s0_aw_burst} = '0;
    {s0_w_valid, s0_w_data, s0_w_strb, s0_w_last, s0_b_ready} = '0;
    {s1_ar_valid, s1_ar_addr, s1_ar_id, s1_ar_len, s1_ar_size, s1_ar_burst, s1_r_ready} = '0;
    {s1_aw_valid, s1_aw_addr, s1_aw_id, s1_aw_len, s1_aw_size, s1_aw_burst} = '0;
    {s1_w_valid, s1_w_data, s1_w_strb, s1_w_last, s1_b_ready} = '0;
    {m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last, m_r_id} = '0;
    {m_aw_ready, m_w_ready, m_b_valid, m_b_resp, m_b_id} = '0;
  endtask

  // One read-path cycle: inputs applied, then expected combinational outputs.
  typedef struct {
    logic        rst, s0_arv, s1_arv, m_arr, m_rv, m_rl;
    logic [63:0] rdata;
    logic        e_arv;
    logic [31:0] e_addr;
    logic        e_s0_arr, e_s1_arr, e_rr, e_s0_rv, e_s1_rv;
  } rvec_t;
  rvec_t rq[$];

  // in = {rst,s0_arv,s1_arv,m_arr,m_rv,m_rl}; eo = {s0_arr,s1_arr,m_rr,s0_rv,s1_rv}
  task automatic addv(input logic [5:0] in, input logic [63:0] rd, input logic earv,
                      input logic [31:0] ea, input logic [4:0] eo);
    rvec_t v;
    v = '{in[5], in[4], in[3], in[2], in[1], in[0], rd, earv, ea, eo[4], eo[3], eo[2], eo[1], eo[0]};
    rq.push_back(v);
  endtask

  localparam logic [31:0] A0 = 32'h8000_0000, A1 = 32'h9000_0000;
  localparam logic [63:0] RD = 64'h1111_2222_0000_0000;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k, beats, lasts;
    logic hs;
    clear_inputs();
    reset = 1'b0;
    // single read s0 len=3
    addv(6'b010000, '0,      1'b0, '0, 5'b00000);
    addv(6'b010000, '0,      1'b1, A0, 5'b00000);
    addv(6'b010100, '0,      1'b1, A0, 5'b10000);
    addv(6'b000010, RD + 0,  1'b0, '0, 5'b00110);
    addv(6'b000010, RD + 1,  1'b0, '0, 5'b00110);
    addv(6'b000010, RD + 2,  1'b0, '0, 5'b00110);
    addv(6'b000011, RD + 3,  1'b0, '0, 5'b00110);
    addv(6'b000000, '0,      1'b0, '0, 5'b00000);
    // reset, then contention: s0, s1 (pointer), s0 again
    addv(6'b111000, '0,      1'b0, '0, 5'b00000);
    addv(6'b011100, '0,      1'b1, A0, 5'b10000);
    addv(6'b001011, RD + 4,  1'b0, '0, 5'b00110);
    addv(6'b011000, '0,      1'b0, '0, 5'b00000);
    addv(6'b011100, '0,      1'b1, A1, 5'b01000);
    addv(6'b010011, RD + 5,  1'b0, '0, 5'b00101);
    addv(6'b011000, '0,      1'b0, '0, 5'b00000);
    addv(6'b011100, '0,      1'b1, A0, 5'b10000);
    addv(6'b001011, RD + 6,  1'b0, '0, 5'b00110);
    addv(6'b000000, '0,      1'b0, '0, 5'b00000);

    repeat (2) @(negedge clock);
    #1 chk("reset_outputs", 64'(any_out), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    s0_ar_addr = A0; s0_ar_len = 8'd3; s1_ar_addr = A1;
    s0_r_ready = 1'b1; s1_r_ready = 1'b1;

    for (int unsigned i = 0; i < rq.size(); i++) begin
      @(negedge clock);
      if (rq[i].rst) begin
        reset = 1'b0;
        #1 chk($sformatf("rvec%0d.reset_outs", i), 64'(any_out), 64'd0);
        reset = 1'b1;
      end
      s0_ar_valid = rq[i].s0_arv; s1_ar_valid = rq[i].s1_arv; m_ar_ready = rq[i].m_arr;
      m_r_valid = rq[i].m_rv; m_r_last = rq[i].m_rl; m_r_data = rq[i].rdata;
      #1;
      chk($sformatf("rvec%0d.m_ar_valid", i), 64'(m_ar_valid), 64'(rq[i].e_arv));
      chk($sformatf("rvec%0d.m_ar_addr", i), 64'(m_ar_addr), 64'(rq[i].e_addr));
      chk($sformatf("rvec%0d.s0_ar_ready", i), 64'(s0_ar_ready), 64'(rq[i].e_s0_arr));
      chk($sformatf("rvec%0d.s1_ar_ready", i), 64'(s1_ar_ready), 64'(rq[i].e_s1_arr));
      chk($sformatf("rvec%0d.m_r_ready", i), 64'(m_r_ready), 64'(rq[i].e_rr));
      chk($sformatf("rvec%0d.s0_r_valid", i), 64'(s0_r_valid), 64'(rq[i].e_s0_rv));
      chk($sformatf("rvec%0d.s1_r_valid", i), 64'(s1_r_valid), 64'(rq[i].e_s1_rv));
      chk($sformatf("rvec%0d.s0_r_data", i), s0_r_data, rq[i].e_s0_rv ? rq[i].rdata : 64'd0);
      chk($sformatf("rvec%0d.s1_r_data", i), s1_r_data, rq[i].e_s1_rv ? rq[i].rdata : 64'd0);
    end

    // concurrent: s0 reads len=1 while s1 writes len=1
    @(negedge clock);
    clear_inputs();
    s0_ar_valid = 1'b1; s0_ar_addr = 32'h8000_1000; s0_ar_id = 4'd3; s0_ar_len = 8'd1;
    s0_ar_size = 3'd3; s0_ar_burst = 2'd1; s0_r_ready = 1'b1;
    s1_aw_valid = 1'b1; s1_aw_addr = 32'h8000_2000; s1_aw_id = 4'd5; s1_aw_len = 8'd1;
    s1_aw_size = 3'd3; s1_aw_burst = 2'd1; s1_b_ready = 1'b1;
    s1_w_valid = 1'b1; s1_w_data = 64'hD0; s1_w_strb = 8'hFF;
    m_ar_ready = 1'b1; m_aw_ready = 1'b1; m_w_ready = 1'b1;
    #1 chk("conc.idle_outs", 64'(any_out), 64'd0);
    @(negedge clock); #1;
    chk("conc.m_ar_valid", 64'(m_ar_valid), 64'd1);
    chk("conc.m_ar_id", 64'(m_ar_id), 64'd3);
    chk("conc.m_ar_len", 64'(m_ar_len), 64'd1);
    chk("conc.m_aw_valid", 64'(m_aw_valid), 64'd1);
    chk("conc.m_aw_id", 64'(m_aw_id), 64'd5);
    chk("conc.m_aw_addr", 64'(m_aw_addr), 64'h8000_2000);
    chk("conc.m_w_valid_addr", 64'(m_w_valid), 64'd0);
    chk("conc.s1_aw_ready", 64'(s1_aw_ready), 64'd1);
    @(negedge clock);
    s0_ar_valid = 1'b0; s1_aw_valid = 1'b0;
    m_r_valid = 1'b1; m_r_data = 64'hAB0; m_r_id = 4'd3;
    #1;
    chk("conc.s0_r_valid", 64'(s0_r_valid), 64'd1);
    chk("conc.s0_r_data0", s0_r_data, 64'hAB0);
    chk("conc.s0_r_id", 64'(s0_r_id), 64'd3);
    chk("conc.s1_r_valid", 64'(s1_r_valid), 64'd0);
    chk("conc.m_w_valid", 64'(m_w_valid), 64'd1);
    chk("conc.m_w_data0", m_w_data, 64'hD0);
    chk("conc.m_w_strb", 64'(m_w_strb), 64'hFF);
    chk("conc.s1_w_ready", 64'(s1_w_ready), 64'd1);
    @(negedge clock);
    m_r_data = 64'hAB1; m_r_last = 1'b1; s1_w_data = 64'hD1; s1_w_last = 1'b1;
    #1;
    chk("conc.s0_r_last", 64'(s0_r_last), 64'd1);
    chk("conc.s0_r_data1", s0_r_data, 64'hAB1);
    chk("conc.m_w_last", 64'(m_w_last), 64'd1);
    chk("conc.m_w_data1", m_w_data, 64'hD1);
    @(negedge clock);
    m_r_valid = 1'b0; m_r_last = 1'b0; s1_w_valid = 1'b0; s1_w_last = 1'b0;
    m_b_valid = 1'b1; m_b_resp = 2'd0; m_b_id = 4'd5;
    #1;
    chk("conc.s1_b_valid", 64'(s1_b_valid), 64'd1);
    chk("conc.s1_b_id", 64'(s1_b_id), 64'd5);
    chk("conc.s1_b_resp", 64'(s1_b_resp), 64'd0);
    chk("conc.s0_b_valid", 64'(s0_b_valid), 64'd0);
    chk("conc.m_b_ready", 64'(m_b_ready), 64'd1);
    chk("conc.m_w_valid_resp", 64'(m_w_valid), 64'd0);
    @(negedge clock);
    m_b_valid = 1'b0;
    #1 chk("conc.done_outs", 64'(any_out), 64'd0);

    // AR backpressure: ar_ready low for 5 cycles
    @(negedge clock);
    clear_inputs();
    s1_ar_valid = 1'b1; s1_ar_addr = 32'h9000_0040; s1_r_ready = 1'b1;
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clock); #1;
      chk($sformatf("bp.ar_valid%0d", c), 64'(m_ar_valid), 64'd1);
      chk($sformatf("bp.ar_addr%0d", c), 64'(m_ar_addr), 64'h9000_0040);
      chk($sformatf("bp.s1_ar_ready%0d", c), 64'(s1_ar_ready), 64'd0);
    end
    @(negedge clock);
    m_ar_ready = 1'b1;
    #1 chk("bp.s1_ar_ready_hs", 64'(s1_ar_ready), 64'd1);
    @(negedge clock);
    s1_ar_valid = 1'b0; m_ar_ready = 1'b0;
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_data = 64'hBEEF;
    #1;
    chk("bp.s1_r_valid", 64'(s1_r_valid), 64'd1);
    chk("bp.s1_r_data", s1_r_data, 64'hBEEF);

    // W backpressure: s0 write len=3 with w_ready toggling
    @(negedge clock);
    clear_inputs();
    s0_aw_valid = 1'b1; s0_aw_addr = 32'h8000_3000; s0_aw_len = 8'd3; s0_b_ready = 1'b1;
    m_aw_ready = 1'b1;
    @(negedge clock);
    #1 chk("wbp.m_aw_valid", 64'(m_aw_valid), 64'd1);
    k = 0; beats = 0; lasts = 0;
    for (int unsigned cyc = 0; cyc < 40 && k < 4; cyc++) begin
      @(negedge clock);
      s0_aw_valid = 1'b0; m_aw_ready = 1'b0;
      s0_w_valid = 1'b1; s0_w_data = 64'hA0 + 64'(k); s0_w_last = (k == 3);
      s0_w_strb = 8'hFF; m_w_ready = cyc[0];
      #1;
      chk($sformatf("wbp.s0_w_ready%0d", cyc), 64'(s0_w_ready), 64'(cyc[0]));
      hs = m_w_valid && m_w_ready;
      if (hs) begin
        chk($sformatf("wbp.beat%0d", k), m_w_data, 64'hA0 + 64'(k));
        beats++;
        if (m_w_last) lasts++;
        k++;
      end
    end
    chk("wbp.beats", 64'(beats), 64'd4);
    chk("wbp.last_count", 64'(lasts), 64'd1);
    @(negedge clock);
    s0_w_valid = 1'b0; s0_w_last = 1'b0; m_w_ready = 1'b0;
    m_b_valid = 1'b1; m_b_id = 4'd7;
    #1;
    chk("wbp.m_w_valid_resp", 64'(m_w_valid), 64'd0);
    chk("wbp.s0_b_valid", 64'(s0_b_valid), 64'd1);
    chk("wbp.s0_b_id", 64'(s0_b_id), 64'd7);

    // reset during R_DATA after two of four beats
    @(negedge clock);
    clear_inputs();
    s0_ar_valid = 1'b1; s0_ar_addr = A0; s0_ar_len = 8'd3; s0_r_ready = 1'b1; m_ar_ready = 1'b1;
    @(negedge clock);
    #1 chk("rst.m_ar_valid", 64'(m_ar_valid), 64'd1);
    for (int unsigned b = 0; b < 2; b++) begin
      @(negedge clock);
      s0_ar_valid = 1'b0; m_r_valid = 1'b1; m_r_data = 64'hC0 + 64'(b);
      #1 chk($sformatf("rst.beat%0d", b), s0_r_data, 64'hC0 + 64'(b));
    end
    @(negedge clock);
    m_r_data = 64'hC2;
    #1 chk("rst.beat2_pending", 64'(s0_r_valid), 64'd1);
    #1 reset = 1'b0;
    #1 chk("rst.async_outs", 64'(any_out), 64'd0);
    @(negedge clock);
    m_r_valid = 1'b0; reset = 1'b1;
    s1_ar_valid = 1'b1; s1_ar_addr = 32'h9000_0080; s1_r_ready = 1'b1;
    #1 chk("rst.release_outs", 64'(any_out), 64'd0);
    @(negedge clock); #1;
    chk("rst.s1_m_ar_valid", 64'(m_ar_valid), 64'd1);
    chk("rst.s1_m_ar_addr", 64'(m_ar_addr), 64'h9000_0080);
    chk("rst.s1_ar_ready", 64'(s1_ar_ready), 64'd1);
    @(negedge clock);
    s1_ar_valid = 1'b0; m_ar_ready = 1'b0;
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_data = 64'hD00D;
    #1;
    chk("rst.s1_r_valid", 64'(s1_r_valid), 64'd1);
    chk("rst.s1_r_data", s1_r_data, 64'hD00D);
    chk("rst.s0_r_valid", 64'(s0_r_valid), 64'd0);
    @(negedge clock);
    clear_inputs();
    #1 chk("rst.final_idle", 64'(any_out), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
